// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: glyph constants (gfedcba, lit=1), the blank
// pattern, reader FSM state encoding and a code->glyph helper for the
// display-side encoder.
package seg7_pkg;

    localparam logic [6:0] SEG7_GLYPH_0 = 7'h3F;
    localparam logic [6:0] SEG7_GLYPH_1 = 7'h06;
    localparam logic [6:0] SEG7_GLYPH_2 = 7'h5B;
    localparam logic [6:0] SEG7_GLYPH_3 = 7'h4F;
    localparam logic [6:0] SEG7_GLYPH_4 = 7'h66;
    localparam logic [6:0] SEG7_GLYPH_5 = 7'h6D;
    localparam logic [6:0] SEG7_GLYPH_6 = 7'h7D;
    localparam logic [6:0] SEG7_GLYPH_7 = 7'h07;
    localparam logic [6:0] SEG7_GLYPH_8 = 7'h7F;
    localparam logic [6:0] SEG7_GLYPH_9 = 7'h6F;
    localparam logic [6:0] SEG7_GLYPH_A = 7'h77;
    localparam logic [6:0] SEG7_GLYPH_B = 7'h7C;
    localparam logic [6:0] SEG7_GLYPH_C = 7'h39;
    localparam logic [6:0] SEG7_GLYPH_D = 7'h5E;
    localparam logic [6:0] SEG7_GLYPH_E = 7'h79;
    localparam logic [6:0] SEG7_GLYPH_F = 7'h71;

    localparam logic [6:0] SEG7_BLANK   = 7'h00;

    typedef enum logic [0:0] {
        SEG7_RD_SETTLE = 1'b0,
        SEG7_RD_LOCKED = 1'b1
    } seg7_rd_state_e;

    // Hex code to lit-segment pattern, used by the display-side encoder.
    function automatic logic [6:0] seg7_encode(input logic [3:0] code);
        logic [6:0] pat;
        pat = SEG7_BLANK;
        case (code)
            4'h0: pat = SEG7_GLYPH_0;
            4'h1: pat = SEG7_GLYPH_1;
            4'h2: pat = SEG7_GLYPH_2;
            4'h3: pat = SEG7_GLYPH_3;
            4'h4: pat = SEG7_GLYPH_4;
            4'h5: pat = SEG7_GLYPH_5;
            4'h6: pat = SEG7_GLYPH_6;
            4'h7: pat = SEG7_GLYPH_7;
            4'h8: pat = SEG7_GLYPH_8;
            4'h9: pat = SEG7_GLYPH_9;
            4'hA: pat = SEG7_GLYPH_A;
            4'hB: pat = SEG7_GLYPH_B;
            4'hC: pat = SEG7_GLYPH_C;
            4'hD: pat = SEG7_GLYPH_D;
            4'hE: pat = SEG7_GLYPH_E;
            4'hF: pat = SEG7_GLYPH_F;
            default: pat = SEG7_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph decoder: lit-segment pattern (gfedcba) -> hex code.
// legal is 0 for any pattern outside the 16-entry glyph table (including blank).
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       legal
);

    // Reverse lookup of the shared glyph table
    always_comb begin
        code  = 4'h0;
        legal = 1'b1;
        case (pattern)
            SEG7_GLYPH_0: code = 4'h0;
            SEG7_GLYPH_1: code = 4'h1;
            SEG7_GLYPH_2: code = 4'h2;
            SEG7_GLYPH_3: code = 4'h3;
            SEG7_GLYPH_4: code = 4'h4;
            SEG7_GLYPH_5: code = 4'h5;
            SEG7_GLYPH_6: code = 4'h6;
            SEG7_GLYPH_7: code = 4'h7;
            SEG7_GLYPH_8: code = 4'h8;
            SEG7_GLYPH_9: code = 4'h9;
            SEG7_GLYPH_A: code = 4'hA;
            SEG7_GLYPH_B: code = 4'hB;
            SEG7_GLYPH_C: code = 4'hC;
            SEG7_GLYPH_D: code = 4'hD;
            SEG7_GLYPH_E: code = 4'hE;
            SEG7_GLYPH_F: code = 4'hF;
            default: begin
                code  = 4'h0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// 7-segment link receiver: synchronises the asynchronous segment pins,
// waits for a pattern to hold STABLE_CYCLES clocks, then decodes it and
// strobes digit_valid (legal glyph) or pattern_err (illegal pattern).
// Optional feature: define SEG7_READER_ERRCNT_EN to add a saturating
// 8-bit err_count output counting pattern_err pulses.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter bit          ACTIVE_LOW    = 1'b1,
    localparam int unsigned CNT_W        = $clog2(STABLE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       pattern_err,
    output logic       blank,
    output logic       locked
`ifdef SEG7_READER_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [6:0]       SYNC_RST = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    seg7_rd_state_e   state_q, state_d;
    logic [6:0]       sync1_q, sync2_q;
    logic [6:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       last_pat_q, last_pat_d;
    logic [3:0]       digit_q, digit_d;
    logic             digit_valid_q, digit_valid_d;
    logic             pattern_err_q, pattern_err_d;
    logic             blank_q, blank_d;
    logic             locked_q, locked_d;
`ifdef SEG7_READER_ERRCNT_EN
    logic [7:0]       err_count_q, err_count_d;
`endif

    logic [6:0]       seg_n;
    logic             pat_change;
    logic             accept;
    logic [3:0]       dec_code;
    logic             dec_legal;

    assign seg_n      = ACTIVE_LOW ? ~sync2_q : sync2_q;
    assign pat_change = (seg_n != cand_q);

    seg7_glyph_decode u_decode (
        .pattern (cand_q),
        .code    (dec_code),
        .legal   (dec_legal)
    );

    // Synchroniser, FSM state and all datapath/output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SEG7_RD_SETTLE;
            sync1_q       <= SYNC_RST;
            sync2_q       <= SYNC_RST;
            cand_q        <= '0;
            cnt_q         <= '0;
            last_pat_q    <= '0;
            digit_q       <= '0;
            digit_valid_q <= 1'b0;
            pattern_err_q <= 1'b0;
            blank_q       <= 1'b1;
            locked_q      <= 1'b0;
`ifdef SEG7_READER_ERRCNT_EN
            err_count_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            sync1_q       <= seg_in;
            sync2_q       <= sync1_q;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            last_pat_q    <= last_pat_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
            pattern_err_q <= pattern_err_d;
            blank_q       <= blank_d;
            locked_q      <= locked_d;
`ifdef SEG7_READER_ERRCNT_EN
            err_count_q   <= err_count_d;
`endif
        end
    end

    // Next-state logic: settle until the candidate has held long enough
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            SEG7_RD_SETTLE: begin
                if (!pat_change && (cnt_q == CNT_LAST)) begin
                    state_d = SEG7_RD_LOCKED;
                    accept  = 1'b1;
                end
            end
            SEG7_RD_LOCKED: begin
                if (pat_change) begin
                    state_d = SEG7_RD_SETTLE;
                end
            end
            default: state_d = SEG7_RD_SETTLE;
        endcase
    end

    // Datapath and outputs: candidate tracking, stability count, accept actions
    always_comb begin
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        last_pat_d    = last_pat_q;
        digit_d       = digit_q;
        digit_valid_d = 1'b0;
        pattern_err_d = 1'b0;
        blank_d       = blank_q;
        locked_d      = locked_q;
`ifdef SEG7_READER_ERRCNT_EN
        err_count_d   = err_count_q;
`endif

        if (pat_change) begin
            cand_d   = seg_n;
            cnt_d    = '0;
            locked_d = 1'b0;
        end else if ((state_q == SEG7_RD_SETTLE) && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (accept) begin
            locked_d   = 1'b1;
            last_pat_d = cand_q;
            // Re-accepting the previous pattern (after a glitch) is silent
            if (cand_q != last_pat_q) begin
                if (cand_q == SEG7_BLANK) begin
                    blank_d = 1'b1;
                end else if (dec_legal) begin
                    digit_d       = dec_code;
                    blank_d       = 1'b0;
                    digit_valid_d = 1'b1;
                end else begin
                    blank_d       = 1'b0;
                    pattern_err_d = 1'b1;
`ifdef SEG7_READER_ERRCNT_EN
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
`endif
                end
            end
        end
    end

    assign digit       = digit_q;
    assign digit_valid = digit_valid_q;
    assign pattern_err = pattern_err_q;
    assign blank       = blank_q;
    assign locked      = locked_q;
`ifdef SEG7_READER_ERRCNT_EN
    assign err_count   = err_count_q;
`endif

endmodule

// File: tb/tb_seg7_reader.sv
// Scoreboard bench for seg7_reader (STABLE_CYCLES=8, ACTIVE_LOW=1).
// The driver models acceptance per held pin pattern: a pattern sampled on
// edges E0..E0+H-1 is accepted iff H >= S+1, with the strobe visible after
// edge E0+S+2. Expected strobes go into a queue; a negedge monitor pops them.
module tb_seg7_reader;

    localparam int unsigned S = 8;
    localparam logic [6:0] GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct {
        bit         is_err;
        logic [3:0] digit;
        int         cyc;
        logic [7:0] errc;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg_in;
    logic [3:0] digit;
    logic       digit_valid;
    logic       pattern_err;
    logic       blank;
    logic       locked;
`ifdef SEG7_READER_ERRCNT_EN
    logic [7:0] err_count;
`endif

    seg7_reader #(
        .STABLE_CYCLES (S),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .digit       (digit),
        .digit_valid (digit_valid),
        .pattern_err (pattern_err),
        .blank       (blank),
        .locked      (locked)
`ifdef SEG7_READER_ERRCNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    ev_t exp_q[$];

    // reference model state
    logic [6:0] last_pat;
    logic [3:0] exp_digit;
    bit         exp_blank;
    int         exp_err;
    logic [6:0] run_pat;
    int         run_start;
    int         run_len;
    bit         run_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int glyph_index(input logic [6:0] pat);
        for (int i = 0; i < 16; i++) begin
            if (GLYPHS[i] == pat) return i;
        end
        return -1;
    endfunction

    task automatic model_accept(input logic [6:0] pat, input int when);
        ev_t e;
        int  idx;
        if (pat == last_pat) return;
        idx = glyph_index(pat);
        if (pat == 7'h00) begin
            exp_blank = 1'b1;
        end else if (idx >= 0) begin
            exp_digit = 4'(idx);
            exp_blank = 1'b0;
            e.is_err = 1'b0; e.digit = exp_digit; e.cyc = when; e.errc = 8'(exp_err);
            exp_q.push_back(e);
        end else begin
            exp_blank = 1'b0;
            if (exp_err < 255) exp_err++;
            e.is_err = 1'b1; e.digit = exp_digit; e.cyc = when; e.errc = 8'(exp_err);
            exp_q.push_back(e);
        end
        last_pat = pat;
    endtask

    task automatic model_reset();
        last_pat  = 7'h00;
        exp_digit = 4'h0;
        exp_blank = 1'b1;
        exp_err   = 0;
    endtask

    // Called at posedge+#1; pat is the normalised (lit=1) pattern.
    task automatic drive(input logic [6:0] pat, input int hold);
        if (pat != run_pat) begin
            run_pat   = pat;
            run_start = cyc + 1;
            run_len   = 0;
            run_done  = 1'b0;
        end
        seg_in  = ~pat;
        run_len += hold;
        if (!run_done && run_len >= int'(S) + 1) begin
            run_done = 1'b1;
            model_accept(pat, run_start + int'(S) + 2);
        end
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic check_levels(input string tag);
        chk({tag, "_digit"}, 32'(digit), 32'(exp_digit));
        chk({tag, "_blank"}, 32'(blank), 32'(exp_blank));
        chk({tag, "_locked"}, 32'(locked), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_digit"}, 32'(digit), 32'd0);
        chk({tag, "_dv"}, 32'(digit_valid), 32'd0);
        chk({tag, "_perr"}, 32'(pattern_err), 32'd0);
        chk({tag, "_blank"}, 32'(blank), 32'd1);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
`ifdef SEG7_READER_ERRCNT_EN
        chk({tag, "_errcnt"}, 32'(err_count), 32'd0);
`endif
    endtask

    // Monitor: every strobe must match the next expected event
    bit prev_strobe = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            prev_strobe = 1'b0;
        end else begin
            if (digit_valid || pattern_err) begin
                chk("strobe_exclusive", 32'(digit_valid && pattern_err), 32'd0);
                chk("strobe_not_back_to_back", 32'(prev_strobe), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got dv=%0b perr=%0b digit=%0h expected none (cycle %0d)",
                             digit_valid, pattern_err, digit, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_kind_perr", 32'(pattern_err), 32'(e.is_err));
                    chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
                    chk("strobe_digit", 32'(digit), 32'(e.digit));
                    chk("strobe_blank", 32'(blank), 32'd0);
                    chk("strobe_locked", 32'(locked), 32'd1);
`ifdef SEG7_READER_ERRCNT_EN
                    chk("strobe_errcnt", 32'(err_count), 32'(e.errc));
`endif
                end
            end
            prev_strobe = digit_valid || pattern_err;
        end
    end

    initial begin
        rst_n  = 1'b0;
        seg_in = 7'h7F;
        model_reset();
        run_pat   = 7'h00;
        run_start = 0;
        run_len   = 0;
        run_done  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        // glyph 5, latency E0+10
        drive(GLYPHS[5], 20);
        check_levels("g5");

        // short glitch to 8 (5 cycles), then back to 5: silent relock
        drive(GLYPHS[8], 3);
        chk("glitch_locked_low", 32'(locked), 32'd0);
        drive(GLYPHS[8], 2);
        chk("glitch_digit_held", 32'(digit), 32'd5);
        drive(GLYPHS[5], 20);
        check_levels("relock5");

        // illegal single segment a
        drive(7'h01, 20);
        check_levels("illegal");
        chk("illegal_digit_5", 32'(digit), 32'd5);

        // blank then 0
        drive(7'h00, 20);
        check_levels("blank");
        drive(GLYPHS[0], 20);
        check_levels("zero");

        // F then step 0..F: 16 valid pulses including the F->0 wrap
        drive(GLYPHS[15], 12);
        for (int i = 0; i < 16; i++) begin
            drive(GLYPHS[i], 12);
        end
        drive(GLYPHS[15], 8);
        check_levels("step_end");

        // randomized pattern/hold sequence around the acceptance boundary
        for (int n = 0; n < 60; n++) begin
            logic [6:0] p;
            int unsigned sel;
            sel = $urandom_range(0, 9);
            if (sel < 6)       p = GLYPHS[$urandom_range(0, 15)];
            else if (sel == 6) p = 7'h00;
            else               p = 7'($urandom);
            drive(p, int'($urandom_range(1, 2 * S + 2)));
        end
        drive(GLYPHS[$urandom_range(0, 15)], 20);
        check_levels("rand_end");

`ifdef SEG7_READER_ERRCNT_EN
        // 300 error events -> saturates at FF
        for (int i = 0; i < 300; i++) begin
            drive((i % 2 == 0) ? 7'h01 : 7'h02, 12);
        end
        chk("errcnt_saturated", 32'(err_count), 32'hFF);
`endif

        // reset mid-settle, then full-latency accept of the held glyph
        drive(GLYPHS[1], 20);
        drive(GLYPHS[3], 3);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        run_pat   = GLYPHS[3];
        run_start = cyc + 1;
        run_len   = 0;
        run_done  = 1'b0;
        drive(GLYPHS[3], 20);
        check_levels("after_reset");

        repeat (30) @(posedge clk);
        #1;
        chk("pending_expected_strobes", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound on simulation length
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
